// File: rtl/i2c_table_config_if.sv
// Request/acknowledge bus between the table configurator and i2c_master_top.
// The configurator uses the master modport; the I2C engine (or a bench model) uses slave.
interface i2c_table_config_if;
    logic       i2c_write_req;
    logic       i2c_write_req_ack;
    logic       i2c_read_req;
    logic       i2c_read_req_ack;
    logic [7:0] i2c_slave_dev_addr;
    logic [7:0] i2c_slave_reg_addr;
    logic [7:0] i2c_write_data;
    logic [7:0] i2c_read_data;
    logic       i2c_error;

    modport master (
        output i2c_write_req, i2c_read_req,
        output i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data,
        input  i2c_write_req_ack, i2c_read_req_ack, i2c_read_data, i2c_error
    );

    modport slave (
        input  i2c_write_req, i2c_read_req,
        input  i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data,
        output i2c_write_req_ack, i2c_read_req_ack, i2c_read_data, i2c_error
    );
endinterface

// File: rtl/i2c_table_config.sv
// Table-driven I2C register configurator.
// Walks an external {dev_addr,reg_addr,data} table: dev FFh ends the run, dev FEh is a
// delay entry of {reg,data}*DELAY_UNIT cycles, anything else is a register write with
// per-entry retry. Errors are sticky per run and record the first failing index.
// Optional feature macro: I2C_CFG_READBACK_EN adds a read-back verify after every write.
module i2c_table_config #(
    parameter int unsigned TABLE_DEPTH = 256,
    parameter int unsigned INDEX_W     = 8,
    parameter int unsigned INIT_WAIT   = 25000,
    parameter int unsigned DELAY_UNIT  = 1000,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned AUTO_START  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [INDEX_W-1:0] err_index,
    output logic               dev_rst_n,
    output logic [INDEX_W-1:0] tbl_index,
    input  logic [23:0]        tbl_data,
    i2c_table_config_if.master bus
);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(TABLE_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_WRITE,
        S_DELAY,
        S_NEXT,
        S_DONE
`ifdef I2C_CFG_READBACK_EN
        ,S_VERIFY
`endif
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] cnt;
    logic [31:0] dly_len;
    logic [31:0] dly_prod;
    logic [7:0]  attempt;

    logic        run_go;
    logic        write_ack;
    logic        attempt_bad;
    logic        can_retry;
    logic        give_up;
    logic        retry;
    logic [7:0]  fetch_dev;

`ifdef I2C_CFG_READBACK_EN
    logic        read_ack;
    logic        read_bad;

    assign read_ack    = (state == S_VERIFY) && bus.i2c_read_req && bus.i2c_read_req_ack;
    assign read_bad    = bus.i2c_error || (bus.i2c_read_data != bus.i2c_write_data);
    assign attempt_bad = (write_ack && bus.i2c_error) || (read_ack && read_bad);
`else
    logic        unused_readback;

    assign bus.i2c_read_req = 1'b0;
    assign unused_readback  = ^{bus.i2c_read_data, bus.i2c_read_req_ack};
    assign attempt_bad      = write_ack && bus.i2c_error;
`endif

    // dev_rst_n is still low on the first edge after reset, which marks the auto-start point
    assign run_go    = ((state == S_IDLE) && (((AUTO_START != 0) && !dev_rst_n) || start))
                     || ((state == S_DONE) && start);
    assign write_ack = (state == S_WRITE) && bus.i2c_write_req && bus.i2c_write_req_ack;
    assign can_retry = 32'(attempt) < MAX_RETRY;
    assign give_up   = attempt_bad && !can_retry;
    assign retry     = attempt_bad && can_retry;
    assign fetch_dev = tbl_data[23:16];
    assign dly_prod  = 32'(tbl_data[15:0]) * DELAY_UNIT;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (run_go) state_nx = S_WAIT;
            S_WAIT:  if (cnt + 32'd1 >= INIT_WAIT) state_nx = S_FETCH;
            S_FETCH: begin
                if (fetch_dev == 8'hFF)      state_nx = S_DONE;
                else if (fetch_dev == 8'hFE) state_nx = S_DELAY;
                else                         state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (write_ack) begin
`ifdef I2C_CFG_READBACK_EN
                    if (!bus.i2c_error) state_nx = S_VERIFY;
`else
                    if (!bus.i2c_error) state_nx = S_NEXT;
`endif
                    else if (give_up)   state_nx = S_NEXT;
                end
            end
`ifdef I2C_CFG_READBACK_EN
            S_VERIFY: begin
                if (read_ack) begin
                    if (!read_bad)      state_nx = S_NEXT;
                    else if (can_retry) state_nx = S_WRITE;
                    else                state_nx = S_NEXT;
                end
            end
`endif
            S_DELAY: if (cnt + 32'd1 >= dly_len) state_nx = S_NEXT;
            S_NEXT:  state_nx = (tbl_index == LAST_INDEX) ? S_DONE : S_FETCH;
            S_DONE:  if (run_go) state_nx = S_WAIT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: counters, table pointer, status flags and bus request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt                    <= '0;
            dly_len                <= '0;
            attempt                <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            error                  <= 1'b0;
            err_index              <= '0;
            dev_rst_n              <= 1'b0;
            tbl_index              <= '0;
            bus.i2c_write_req      <= 1'b0;
            bus.i2c_slave_dev_addr <= '0;
            bus.i2c_slave_reg_addr <= '0;
            bus.i2c_write_data     <= '0;
`ifdef I2C_CFG_READBACK_EN
            bus.i2c_read_req       <= 1'b0;
`endif
        end else begin
            dev_rst_n <= 1'b1;
            cnt       <= (state_nx != state) ? '0 : cnt + 32'd1;

            if (retry) attempt <= attempt + 8'd1;
            if (give_up) begin
                error <= 1'b1;
                if (!error) err_index <= tbl_index;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (run_go) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        tbl_index <= '0;
                    end
                end
                S_FETCH: begin
                    bus.i2c_slave_dev_addr <= tbl_data[23:16];
                    bus.i2c_slave_reg_addr <= tbl_data[15:8];
                    bus.i2c_write_data     <= tbl_data[7:0];
                    dly_len                <= (dly_prod == 32'd0) ? 32'd1 : dly_prod;
                    attempt                <= '0;
                    if (fetch_dev == 8'hFF) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (fetch_dev != 8'hFE) begin
                        bus.i2c_write_req <= 1'b1;
                    end
                end
                S_WRITE: begin
                    // A retry leaves req low for one cycle, then this re-raises it
                    if (write_ack) begin
                        bus.i2c_write_req <= 1'b0;
`ifdef I2C_CFG_READBACK_EN
                        if (!bus.i2c_error) bus.i2c_read_req <= 1'b1;
`endif
                    end else if (!bus.i2c_write_req) begin
                        bus.i2c_write_req <= 1'b1;
                    end
                end
`ifdef I2C_CFG_READBACK_EN
                S_VERIFY: begin
                    if (read_ack) bus.i2c_read_req <= 1'b0;
                end
`endif
                S_NEXT: begin
                    if (tbl_index == LAST_INDEX) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        tbl_index <= tbl_index + INDEX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
